// File: rtl/pmem_responder_pkg.sv
// Shared types for the line-memory responder: line type, offset width, FSM state.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pmem_responder_pkg;

  localparam int unsigned PMEM_LINE_BITS   = 256;
  localparam int unsigned PMEM_OFFSET_BITS = 5;
  localparam int unsigned PMEM_ADDR_BITS   = 32;
  localparam int unsigned PMEM_CNT_BITS    = 8;

  typedef logic [PMEM_LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Everything the responder latches when it accepts a request.
  typedef struct packed {
    logic                      rd;
    logic                      wr;
    logic [PMEM_ADDR_BITS-1:0] addr;
    line_t                     wdata;
  } req_t;

  // Counter preload: the BUSY countdown ends at zero, so it starts one below the latency.
  function automatic logic [PMEM_CNT_BITS-1:0] latency_load(input int unsigned latency);
    return PMEM_CNT_BITS'(latency - 1);
  endfunction

endpackage

// File: rtl/pmem_array.sv
// Line storage: DEPTH x 256-bit single-port RAM, synchronous write, registered read.
// Latency: write lands at the enabled edge; read data appears after the enabled edge.
// Backpressure: none; one access per enabled cycle. Contents and read register are never reset.
module pmem_array
  import pmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  line_t             wdata,
  output line_t             rdata
);

  line_t mem [DEPTH];

  // Single port: a write or a registered read per enabled cycle; the read register holds otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Fixed-latency line-memory responder: captures a read/write request, completes it LATENCY cycles later.
// Latency: pmem_resp pulses LATENCY cycles after the capturing edge; build option PMEM_RESPONDER_ERR_EN adds pmem_error.
// Backpressure: none; the initiator holds its request until pmem_resp, and requests are only taken in IDLE.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned DEPTH   = 256
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [31:0]  pmem_address,
  input  logic [255:0] pmem_wdata,
  output logic [255:0] pmem_rdata,
`ifdef PMEM_RESPONDER_ERR_EN
  output logic         pmem_resp,
  output logic         pmem_error
`else
  output logic         pmem_resp
`endif
);

  localparam int unsigned IDX_W   = $clog2(DEPTH);
  localparam int unsigned TAG_LSB = PMEM_OFFSET_BITS + IDX_W;

  state_t                   state;
  logic [PMEM_CNT_BITS-1:0] cnt;
  req_t                     req_q;
  logic                     rdata_vld_q;

  logic                     fire;
  logic                     arr_en;
  logic                     arr_we;
  logic [IDX_W-1:0]         line_idx;
  line_t                    arr_rdata;

  // The countdown has expired: this is the edge that enters RESP and performs the array access.
  assign fire     = (state == BUSY) && (cnt == '0);
  assign line_idx = req_q.addr[PMEM_OFFSET_BITS +: IDX_W];

`ifdef PMEM_RESPONDER_ERR_EN
  logic req_err;
  logic err_q;

  // Ambiguous op or address outside the stored range: complete with an error, touch nothing.
  assign req_err    = (req_q.rd & req_q.wr) | (|req_q.addr[PMEM_ADDR_BITS-1:TAG_LSB]);
  assign arr_en     = fire & ~req_err;
  assign arr_we     = req_q.wr;
  assign pmem_error = err_q;
`else
  logic unused_req_bits;

  // Upper address bits alias onto the index, and write wins when both ops are set.
  assign arr_en          = fire;
  assign arr_we          = req_q.wr;
  assign unused_req_bits = ^{req_q.rd, req_q.addr[PMEM_ADDR_BITS-1:TAG_LSB]};
`endif

  logic unused_offset_bits;
  assign unused_offset_bits = ^req_q.addr[PMEM_OFFSET_BITS-1:0];

  // Read data is forced to zero until a read has completed since reset; the array itself is not reset.
  assign pmem_rdata = rdata_vld_q ? arr_rdata : '0;

  pmem_array #(
    .DEPTH  (DEPTH),
    .ADDR_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (line_idx),
    .wdata (req_q.wdata),
    .rdata (arr_rdata)
  );

  // Request FSM: capture in IDLE, count down in BUSY, one-cycle registered completion in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      req_q       <= '0;
      pmem_resp   <= 1'b0;
      rdata_vld_q <= 1'b0;
`ifdef PMEM_RESPONDER_ERR_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          pmem_resp <= 1'b0;
`ifdef PMEM_RESPONDER_ERR_EN
          err_q     <= 1'b0;
`endif
          if (pmem_read || pmem_write) begin
            req_q.rd    <= pmem_read;
            req_q.wr    <= pmem_write;
            req_q.addr  <= pmem_address;
            req_q.wdata <= pmem_wdata;
            cnt         <= latency_load(LATENCY);
            state       <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state     <= RESP;
            pmem_resp <= 1'b1;
`ifdef PMEM_RESPONDER_ERR_EN
            err_q     <= req_err;
`endif
            if (arr_en && !arr_we) begin
              rdata_vld_q <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          // The initiator still holds its request here; it is deliberately not re-captured.
          pmem_resp <= 1'b0;
`ifdef PMEM_RESPONDER_ERR_EN
          err_q     <= 1'b0;
`endif
          state     <= IDLE;
        end
        default: begin
          pmem_resp <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
